// File: rtl/vdff_stream_rx.sv
// vdff_stream_rx: elastic receive FIFO for a non-backpressured source, re-presented as valid/ready.
// Words arriving while full (with no pop) are dropped and flagged on a sticky overflow.
module vdff_stream_rx #(
  parameter int SIZE = 5,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] in,
  input  logic            in_valid,
  output logic [SIZE-1:0] out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   count,
  output logic            overflow,
  input  logic            ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  logic [SIZE-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic overflow_q, overflow_d;
  logic full, push, pop, ovf_ev;
  always_comb begin
    full       = count_q == CW'(DEPTH);
    pop        = out_valid & out_ready;
    push       = in_valid & (!full | pop);
    ovf_ev     = in_valid & full & !pop;
    wr_d       = push ? wr_q + AW'(1) : wr_q;
    rd_d       = pop ? rd_q + AW'(1) : rd_q;
    count_d    = (push & !pop) ? count_q + CW'(1) : (pop & !push) ? count_q - CW'(1) : count_q;
    overflow_d = ovf_ev ? 1'b1 : ovf_clr ? 1'b0 : overflow_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end
  // storage is deliberately unreset; out is masked while empty instead
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= in;
  end
  assign out_valid = count_q != '0;
  assign out       = out_valid ? mem[rd_q] : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_vdff_stream_rx.sv
// tb_vdff_stream_rx: directed checks on the default FIFO plus a wrap/stall run on a SIZE=10, DEPTH=8 instance.
module tb_vdff_stream_rx;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [4:0] a_in, a_out;
  logic a_in_valid, a_out_valid, a_out_ready, a_overflow, a_ovf_clr;
  logic [2:0] a_count;
  logic [9:0] b_in, b_out;
  logic b_in_valid, b_out_valid, b_out_ready, b_overflow, b_ovf_clr, b_rst;
  logic [3:0] b_count;
  int n_chk = 0, n_fail = 0;
  vdff_stream_rx dut_a (
    .clk(clk), .rst(rst), .in(a_in), .in_valid(a_in_valid), .out(a_out), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .count(a_count), .overflow(a_overflow), .ovf_clr(a_ovf_clr)
  );
  vdff_stream_rx #(.SIZE(10), .DEPTH(8)) dut_b (
    .clk(clk), .rst(b_rst), .in(b_in), .in_valid(b_in_valid), .out(b_out), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .count(b_count), .overflow(b_overflow), .ovf_clr(b_ovf_clr)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic a_push(input logic [4:0] w);
    a_in = w;
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [9:0] q[$];
    int sent, cyc;
    a_in = '0; a_in_valid = 0; a_out_ready = 0; a_ovf_clr = 0;
    b_in = '0; b_in_valid = 0; b_out_ready = 0; b_ovf_clr = 0; b_rst = 1;
    step(); step();
    rst = 0; b_rst = 0;
    chk("rst_count", a_count, 0);
    chk("rst_valid", a_out_valid, 0);
    chk("rst_out", a_out, 0);
    chk("rst_ovf", a_overflow, 0);
    // single word
    a_out_ready = 1;
    a_push(5'h15);
    chk("single_valid", a_out_valid, 1);
    chk("single_out", a_out, 5'h15);
    step();
    chk("single_cnt0", a_count, 0);
    chk("single_out0", a_out, 0);
    // fill, overflow, drain
    a_out_ready = 0;
    for (int i = 1; i <= 4; i++) a_push(5'(i));
    chk("fill_count", a_count, 4);
    chk("fill_head", a_out, 5'h01);
    a_push(5'h1F);
    chk("ovf_count", a_count, 4);
    chk("ovf_flag", a_overflow, 1);
    a_out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain", a_out, 5'(i));
      step();
    end
    a_out_ready = 0;
    chk("drain_empty", a_out_valid, 0);
    chk("ovf_sticky", a_overflow, 1);
    a_ovf_clr = 1; step(); a_ovf_clr = 0;
    chk("ovf_clr", a_overflow, 0);
    for (int i = 1; i <= 4; i++) a_push(5'h10 + 5'(i));
    a_ovf_clr = 1;
    a_push(5'h1F);
    a_ovf_clr = 0;
    chk("ovf_set_wins", a_overflow, 1);
    a_ovf_clr = 1; step(); a_ovf_clr = 0;
    chk("ovf_clr2", a_overflow, 0);
    // full push+pop
    a_out_ready = 1;
    a_push(5'h0A);
    a_out_ready = 0;
    chk("fpp_count", a_count, 4);
    chk("fpp_ovf", a_overflow, 0);
    a_out_ready = 1;
    chk("fpp_d0", a_out, 5'h12); step();
    chk("fpp_d1", a_out, 5'h13); step();
    chk("fpp_d2", a_out, 5'h14); step();
    chk("fpp_d3", a_out, 5'h0A); step();
    chk("fpp_empty", a_out_valid, 0);
    // push+pop at count=1
    a_out_ready = 0;
    a_push(5'h03);
    a_out_ready = 1;
    a_push(5'h09);
    chk("c1_valid", a_out_valid, 1);
    chk("c1_out", a_out, 5'h09);
    chk("c1_count", a_count, 1);
    step();
    chk("c1_empty", a_out_valid, 0);
    // async reset mid-cycle with data and overflow pending
    a_out_ready = 0;
    for (int i = 0; i < 5; i++) a_push(5'h07);
    chk("pre_rst_ovf", a_overflow, 1);
    #3 rst = 1;
    #1;
    chk("arst_count", a_count, 0);
    chk("arst_valid", a_out_valid, 0);
    chk("arst_out", a_out, 0);
    chk("arst_ovf", a_overflow, 0);
    step();
    rst = 0;
    a_push(5'h06);
    chk("post_rst_out", a_out, 5'h06);
    chk("post_rst_cnt", a_count, 1);
    // wide/deep instance: random stalls across pointer wrap
    sent = 0; cyc = 0;
    while ((sent < 20 || q.size() != 0) && cyc < 400) begin
      b_out_ready = $urandom_range(3) != 0;
      b_in_valid = sent < 20 && b_count < 8;
      b_in = 10'($urandom);
      if (b_out_valid && b_out_ready) chk("wrap_seq", b_out, q.pop_front());
      if (b_in_valid) begin
        q.push_back(b_in);
        sent++;
      end
      step();
      cyc++;
    end
    b_in_valid = 0; b_out_ready = 0;
    chk("wrap_done", cyc < 400, 1);
    chk("wrap_ovf", b_overflow, 0);
    chk("wrap_empty", b_count, 0);
    for (int i = 0; i < 3; i++) begin
      b_in = 10'h100 + 10'(i);
      b_in_valid = 1;
      step();
    end
    b_in_valid = 0;
    chk("b_count3", b_count, 3);
    #3 b_rst = 1;
    #1;
    chk("b_arst_count", b_count, 0);
    step();
    b_rst = 0;
    b_in = 10'h2AA; b_in_valid = 1; step();
    b_in = 10'h155; step();
    b_in_valid = 0;
    chk("b_first_out", b_out, 10'h2AA);
    b_out_ready = 1; step();
    chk("b_second_out", b_out, 10'h155);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vdff_stream_rx.md
Name: vdff_stream_rx

Overview:
- Receive-side elastic buffer for SIZE-bit words from a registered, non-backpressured source stage.
- The source launches one word per asserted in_valid and never stalls. This block absorbs the words into a DEPTH-entry FIFO and re-presents them on a valid/ready interface to the downstream consumer.
- It detects and flags overflow, since the source cannot be throttled.
- Sits between a vdff-style parameterized register stage and any consumer that may stall.

Parameters:
- SIZE, 5, data word width in bits (≥1).
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CW, $clog2(DEPTH+1), occupancy count width (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  asynchronous, active-high reset.
- in  input  SIZE  data word from the source stage.
- in_valid  input  1  in carries a new word this cycle; no backpressure to the source.
- out  output  SIZE  head-of-FIFO word; forced to 0 when empty.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out this cycle.
- count  output  CW  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a word was dropped.
- ovf_clr  input  1  clears overflow (synchronous).

Behaviour:
- Reset: asynchronous on rst rising, held while rst=1.
  - wr_ptr=0, rd_ptr=0, count=0, out_valid=0, out=0, overflow=0.
  - Storage contents are not reset.
- push = in_valid & (count<DEPTH | pop); pop = out_valid & out_ready.
- Show-ahead read:
  - out = mem[rd_ptr] combinationally when count>0, else 0.
  - out_valid = (count!=0), derived from the registered count.
- Latency: a word accepted at edge N is visible on out/out_valid after edge N (next cycle). There is no same-cycle bypass when empty.
- Pointers: log2(DEPTH) bits, natural wrap from DEPTH-1 to 0. Full/empty are determined by count, not by pointer compare.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop when full: both happen, count stays DEPTH, no overflow.
- Simultaneous push and pop when count=1: the head advances to the new word; out_valid stays 1.
- Overflow: in_valid=1 & count==DEPTH & !pop.
  - The word is dropped; FIFO contents and pointers are unchanged.
  - overflow is set to 1 at that edge.
- Overflow flag behaviour:
  - overflow stays set until an edge with ovf_clr=1.
  - If ovf_clr and a new overflow event coincide, set wins (overflow=1).
- out_ready with out_valid=0 is ignored. There is no underflow; count never wraps below 0.
- Ordering is strict FIFO. No word is duplicated, and no word is lost except in an overflow event.
- Reset mid-stream: all queued words are discarded; the first word after rst deasserts lands at index 0.
- No X propagation: out is 0 when empty, so the consumer never sees stale data.

Test Plan:
- Reset/idle: assert rst mid-cycle, async -> out_valid=0, count=0, out=0, overflow=0 immediately, without waiting for clk.
- Single word: in=5'h15 with in_valid for 1 cycle, out_ready=1 -> out_valid=1, out=5'h15 the next cycle. Then count=0 and out=0 the cycle after.
- Fill and drain: out_ready=0, push 5'h01..5'h04 -> count=4, out=5'h01. Raise out_ready -> outputs 01,02,03,04 on consecutive cycles. Then out_valid=0.
- Overflow: with FIFO full and out_ready=0, push 5'h1F -> word dropped, count=4, overflow=1, and the drained sequence is still 01..04. Pulse ovf_clr -> overflow=0. Pulse ovf_clr together with a new overflow event -> overflow stays 1.
- Full push+pop: FIFO full, in_valid=1 with 5'h0A, out_ready=1 for 1 cycle -> count stays 4, overflow stays 0, and 5'h0A emerges 4th after the pop.
- Wrap and params: SIZE=10, DEPTH=8, continuous 1-in/1-out traffic for 20 words with random out_ready stalls (no overflow) -> output sequence equals input sequence across pointer wrap. Then rst mid-stream with count=3 -> count=0, and the next pushed word 10'h2AA is the first output.
